// File: rtl/dp_amo_bridge.sv
// rtl/dp_amo_bridge.sv - 32-bit core data port to 64-bit AMO shim bank bridge
// Optional output register stage enabled by defining DP_BRIDGE_RSP_REG_EN.
module dp_amo_bridge #(
   parameter int unsigned AddrMemWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   input  logic [31:0]             data_addr_i,
   input  logic                    data_we_i,
   input  logic [3:0]              data_be_i,
   input  logic [31:0]             data_wdata_i,
   input  logic [5:0]              data_atop_i,
   output logic                    data_rvalid_o,
   output logic [31:0]             data_rdata_o,
   output logic                    data_err_o,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [AddrMemWidth-1:0] mem_add_o,
   output logic [3:0]              mem_amo_o,
   output logic                    mem_wen_o,
   output logic [63:0]             mem_wdata_o,
   output logic [7:0]              mem_be_o,
   input  logic [63:0]             mem_rdata_i
);

   localparam logic [3:0] AMO_NONE = 4'h0;
   localparam logic [3:0] AMO_SWAP = 4'h1;
   localparam logic [3:0] AMO_ADD  = 4'h2;
   localparam logic [3:0] AMO_AND  = 4'h3;
   localparam logic [3:0] AMO_OR   = 4'h4;
   localparam logic [3:0] AMO_XOR  = 4'h5;
   localparam logic [3:0] AMO_MAX  = 4'h6;
   localparam logic [3:0] AMO_MAXU = 4'h7;
   localparam logic [3:0] AMO_MIN  = 4'h8;
   localparam logic [3:0] AMO_MINU = 4'h9;
   localparam logic [3:0] AMO_LR   = 4'hB;
   localparam logic [3:0] AMO_SC   = 4'hC;

   logic [3:0] amo_code;
   logic       funct_ok;
   logic       illegal;
   logic       core_gnt;

   logic       s1_valid;
   logic       s1_lane;
   logic       s1_err;
   logic [31:0] rsp_rdata;
   logic        unused_addr;

   always_comb begin
      amo_code = AMO_NONE;
      funct_ok = 1'b0;
      if (data_atop_i[5]) begin
         funct_ok = 1'b1;
         case (data_atop_i[4:0])
            5'b00001: amo_code = AMO_SWAP;
            5'b00000: amo_code = AMO_ADD;
            5'b01100: amo_code = AMO_AND;
            5'b01000: amo_code = AMO_OR;
            5'b00100: amo_code = AMO_XOR;
            5'b10100: amo_code = AMO_MAX;
            5'b11100: amo_code = AMO_MAXU;
            5'b10000: amo_code = AMO_MIN;
            5'b11000: amo_code = AMO_MINU;
            5'b00010: amo_code = AMO_LR;
            5'b00011: amo_code = AMO_SC;
            default:  funct_ok = 1'b0;
         endcase
      end
   end

   // Bad atomics are answered locally with an error and never reach the shim.
   assign illegal = data_atop_i[5] &
                    (~funct_ok | (data_addr_i[1:0] != 2'b00) | (data_be_i != 4'hF));

   assign core_gnt    = data_req_i & (illegal | mem_gnt_i);
   assign data_gnt_o  = core_gnt;
   assign mem_req_o   = data_req_i & ~illegal;
   assign mem_add_o   = data_addr_i[AddrMemWidth+2:3];
   assign mem_amo_o   = amo_code;
   // Only SC writes among atomics; every other atomic is a read-modify at the shim.
   assign mem_wen_o   = data_we_i & ~(data_atop_i[5] & (amo_code != AMO_SC));
   assign mem_wdata_o = {data_wdata_i, data_wdata_i};
   assign mem_be_o    = data_addr_i[2] ? {data_be_i, 4'b0000} : {4'b0000, data_be_i};
   assign unused_addr = ^{data_addr_i[31:AddrMemWidth+3]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         s1_lane  <= 1'b0;
         s1_err   <= 1'b0;
      end else if (core_gnt) begin
         s1_valid <= 1'b1;
         s1_lane  <= data_addr_i[2];
         s1_err   <= illegal;
      end else begin
         s1_valid <= 1'b0;
      end
   end

   assign rsp_rdata = (s1_valid & ~s1_err) ?
                      (s1_lane ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'h0;

`ifdef DP_BRIDGE_RSP_REG_EN
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= s1_valid;
         rsp_rdata_q <= rsp_rdata;
         rsp_err_q   <= s1_valid & s1_err;
      end
   end

   assign data_rvalid_o = rsp_valid_q;
   assign data_rdata_o  = rsp_rdata_q;
   assign data_err_o    = rsp_err_q;
`else
   assign data_rvalid_o = s1_valid;
   assign data_rdata_o  = rsp_rdata;
   assign data_err_o    = s1_valid & s1_err;
`endif

endmodule
